// File: rtl/emu_scan_ram.sv
// emu_scan_ram
// ------------
// Emulation-friendly RAM with a normal single-read / single-write functional
// port plus a scan chain that can dump the whole contents out, or restore
// them, one CHAIN_WIDTH beat per cycle. Each word is split into
// BEATS = ceil(DATA_WIDTH/CHAIN_WIDTH) beats, least-significant beat first,
// with address 0 first. The last beat of a word is zero-padded on dump, and
// its pad bits are dropped on restore.
//
// Configuration macro:
//   EMU_SCAN_RAM_RDATA_BYPASS_EN - when defined, a functional write and read
//   to the same address in the same cycle returns the new data on rdata.
//   When undefined, the old memory contents are returned.
//
// Ports:
//   clk        - single clock, all logic on the rising edge
//   rst_n      - asynchronous active-low reset (memory array is not cleared)
//   func_en    - functional port enable (0 = paused, rdata holds)
//   raddr      - functional read address
//   rdata      - registered read data (1-cycle latency)
//   wen        - functional write enable
//   waddr      - functional write address
//   wdata      - functional write data
//   scan_en    - scan session active (functional port is frozen while high)
//   scan_dir   - 0 = dump, 1 = restore; sampled only when a session starts
//   scan_di    - restore beat
//   scan_do    - dump beat (0 outside an active dump)
//   scan_done  - every beat of the chain has been transferred

module emu_scan_ram #(
    parameter int DATA_WIDTH  = 80,
    parameter int DEPTH       = 64,
    parameter int CHAIN_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     func_en,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata,
    input  logic                     wen,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     scan_en,
    input  logic                     scan_dir,
    input  logic [CHAIN_WIDTH-1:0]   scan_di,
    output logic [CHAIN_WIDTH-1:0]   scan_do,
    output logic                     scan_done
);

    localparam int AW    = $clog2(DEPTH);
    localparam int BEATS = (DATA_WIDTH + CHAIN_WIDTH - 1) / CHAIN_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PAD_W = BEATS * CHAIN_WIDTH;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        DUMP,
        LOAD,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           word_q, word_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic                    armed_q, armed_d;
    logic [CHAIN_WIDTH-1:0]  scan_do_q, scan_do_d;
    logic                    scan_done_q, scan_done_d;
    logic [PAD_W-1:0]        load_buf_q, load_buf_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    mem_we;
    logic [AW-1:0]           mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic                    func_active;
    logic                    is_last;
    logic [AW-1:0]           nxt_word;
    logic [BW-1:0]           nxt_beat;
    logic [PAD_W-1:0]        assembled;
    logic                    take_beat;
    logic                    advance;
    logic                    go_idle;

    // Pick beat 'idx' out of a word, zero-padding the top beat.
    function automatic logic [CHAIN_WIDTH-1:0] get_beat(
        input logic [DATA_WIDTH-1:0] word,
        input logic [BW-1:0]         idx
    );
        logic [PAD_W-1:0]       padded;
        logic [CHAIN_WIDTH-1:0] beat;
        padded                 = '0;
        padded[DATA_WIDTH-1:0] = word;
        beat                   = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (idx == BW'(i)) begin
                beat = padded[i*CHAIN_WIDTH +: CHAIN_WIDTH];
            end
        end
        return beat;
    endfunction

    // Drop a restore beat into its slot of the word being assembled.
    function automatic logic [PAD_W-1:0] put_beat(
        input logic [PAD_W-1:0]       cur,
        input logic [BW-1:0]          idx,
        input logic [CHAIN_WIDTH-1:0] beat
    );
        logic [PAD_W-1:0] res;
        res = cur;
        for (int i = 0; i < BEATS; i++) begin
            if (idx == BW'(i)) begin
                res[i*CHAIN_WIDTH +: CHAIN_WIDTH] = beat;
            end
        end
        return res;
    endfunction

    assign func_active = func_en & ~scan_en;
    assign is_last     = (word_q == LAST_WORD) && (beat_q == LAST_BEAT);
    assign nxt_beat    = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
    assign nxt_word    = (beat_q == LAST_BEAT) ? word_q + AW'(1) : word_q;
    assign assembled   = put_beat(load_buf_q, beat_q, scan_di);

    // Scan sequencer. word_q/beat_q always name the chain position being
    // handled: in a dump it is the beat currently on scan_do, in a restore
    // it is the beat sampled on this edge. Counters are zero in IDLE, so a
    // new session always starts at address 0, beat 0.
    //
    // armed_q blocks a session from starting until scan_en has been seen
    // low, so a reset in the middle of a session does not restart it while
    // scan_en is still held high.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        beat_d      = beat_q;
        armed_d     = armed_q | ~scan_en;
        scan_do_d   = '0;
        scan_done_d = 1'b0;
        load_buf_d  = load_buf_q;
        mem_we      = func_active & wen;
        mem_waddr   = waddr;
        mem_wdata   = wdata;
        take_beat   = 1'b0;
        advance     = 1'b0;
        go_idle     = 1'b0;

        case (state_q)
            IDLE: begin
                if (scan_en && armed_q) begin
                    if (scan_dir) begin
                        state_d   = LOAD;
                        take_beat = 1'b1;
                        advance   = 1'b1;
                    end else begin
                        // Word 0 is read here so beat 0 is already on
                        // scan_do during the PREFETCH cycle.
                        state_d   = PREFETCH;
                        scan_do_d = get_beat(mem[word_q], beat_q);
                    end
                end
            end

            PREFETCH, DUMP: begin
                if (!scan_en) begin
                    go_idle = 1'b1;
                end else if (is_last) begin
                    state_d     = DONE;
                    scan_done_d = 1'b1;
                end else begin
                    state_d   = DUMP;
                    advance   = 1'b1;
                    scan_do_d = get_beat(mem[nxt_word], nxt_beat);
                end
            end

            LOAD: begin
                if (!scan_en) begin
                    go_idle = 1'b1;
                end else begin
                    take_beat = 1'b1;
                    if (is_last) begin
                        state_d     = DONE;
                        scan_done_d = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end

            DONE: begin
                if (!scan_en) begin
                    go_idle = 1'b1;
                end else begin
                    scan_done_d = 1'b1;
                end
            end

            default: begin
                go_idle = 1'b1;
            end
        endcase

        // A restore only touches memory once a whole word has arrived, so
        // an aborted session never leaves a half-written word behind.
        if (take_beat) begin
            if (beat_q == LAST_BEAT) begin
                mem_we     = 1'b1;
                mem_waddr  = word_q;
                mem_wdata  = assembled[DATA_WIDTH-1:0];
                load_buf_d = '0;
            end else begin
                load_buf_d = assembled;
            end
        end

        if (advance) begin
            word_d = nxt_word;
            beat_d = nxt_beat;
        end

        if (go_idle) begin
            state_d    = IDLE;
            word_d     = '0;
            beat_d     = '0;
            load_buf_d = '0;
        end
    end

    // Sequencer state and registered scan outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            beat_q      <= '0;
            armed_q     <= 1'b0;
            scan_do_q   <= '0;
            scan_done_q <= 1'b0;
            load_buf_q  <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            beat_q      <= beat_d;
            armed_q     <= armed_d;
            scan_do_q   <= scan_do_d;
            scan_done_q <= scan_done_d;
            load_buf_q  <= load_buf_d;
        end
    end

    // Functional read port; rdata holds whenever the port is paused or a
    // scan session owns the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (func_active) begin
`ifdef EMU_SCAN_RAM_RDATA_BYPASS_EN
            rdata <= (wen && (waddr == raddr)) ? wdata : mem[raddr];
`else
            rdata <= mem[raddr];
`endif
        end
    end

    // Storage array: deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign scan_do   = scan_do_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_emu_scan_ram.sv
// tb_emu_scan_ram
// ---------------
// Bench for emu_scan_ram. The default-parameter instance is tracked by a
// cycle-counting reference model and checked every cycle; a second instance
// with DATA_WIDTH=CHAIN_WIDTH=32, DEPTH=16 is exercised with directed checks.

module tb_emu_scan_ram;

    localparam int DW    = 80;
    localparam int CW    = 64;
    localparam int DEPTH = 64;
    localparam int CHAIN = DEPTH * 2;

`ifdef EMU_SCAN_RAM_RDATA_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          func_en = 1'b0;
    logic [5:0]    raddr = '0;
    logic [DW-1:0] rdata;
    logic          wen = 1'b0;
    logic [5:0]    waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic          scan_en = 1'b0;
    logic          scan_dir = 1'b0;
    logic [CW-1:0] scan_di = '0;
    logic [CW-1:0] scan_do;
    logic          scan_done;

    logic          s_func_en = 1'b0;
    logic [3:0]    s_raddr = '0;
    logic [31:0]   s_rdata;
    logic          s_wen = 1'b0;
    logic [3:0]    s_waddr = '0;
    logic [31:0]   s_wdata = '0;
    logic          s_scan_en = 1'b0;
    logic          s_scan_dir = 1'b0;
    logic [31:0]   s_scan_di = '0;
    logic [31:0]   s_scan_do;
    logic          s_scan_done;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    emu_scan_ram u_dut (
        .clk(clk), .rst_n(rst_n), .func_en(func_en), .raddr(raddr),
        .rdata(rdata), .wen(wen), .waddr(waddr), .wdata(wdata),
        .scan_en(scan_en), .scan_dir(scan_dir), .scan_di(scan_di),
        .scan_do(scan_do), .scan_done(scan_done)
    );

    emu_scan_ram #(.DATA_WIDTH(32), .DEPTH(16), .CHAIN_WIDTH(32)) u_small (
        .clk(clk), .rst_n(rst_n), .func_en(s_func_en), .raddr(s_raddr),
        .rdata(s_rdata), .wen(s_wen), .waddr(s_waddr), .wdata(s_wdata),
        .scan_en(s_scan_en), .scan_dir(s_scan_dir), .scan_di(s_scan_di),
        .scan_do(s_scan_do), .scan_done(s_scan_done)
    );

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (default instance) ----------------
    logic [DW-1:0]  mdl_mem [DEPTH];
    bit             mdl_known [DEPTH];
    logic [DW-1:0]  exp_rdata;
    bit             exp_rk;
    logic [CW-1:0]  exp_do;
    bit             exp_done;
    bit             sess, sdir, armed;
    int             n;
    logic [127:0]   ld_buf;

    function automatic logic [CW-1:0] model_beat(input int k);
        logic [127:0] t;
        t = 128'(mdl_mem[k/2]);
        return (k % 2 == 1) ? t[127:64] : t[63:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_rdata = '0;
            exp_rk    = 1'b1;
            exp_do    = '0;
            exp_done  = 1'b0;
            sess      = 1'b0;
            armed     = 1'b0;
            n         = 0;
        end else begin
            if (func_en && !scan_en) begin
                if (BYP && wen && waddr == raddr) begin
                    exp_rdata = wdata;
                    exp_rk    = 1'b1;
                end else begin
                    exp_rdata = mdl_mem[raddr];
                    exp_rk    = mdl_known[raddr];
                end
                if (wen) begin
                    mdl_mem[waddr]   = wdata;
                    mdl_known[waddr] = 1'b1;
                end
            end
            if (!sess && scan_en && armed) begin
                sess = 1'b1;
                sdir = scan_dir;
                n    = 0;
            end else if (sess && !scan_en) begin
                sess = 1'b0;
            end
            armed = armed | !scan_en;
            if (sess) begin
                n++;
                if (!sdir) begin
                    exp_do   = (n - 1 < CHAIN) ? model_beat(n - 1) : '0;
                    exp_done = (n - 1 >= CHAIN);
                end else begin
                    exp_do = '0;
                    if (n - 1 < CHAIN) begin
                        if ((n - 1) % 2 == 0) begin
                            ld_buf[63:0] = scan_di;
                        end else begin
                            ld_buf[127:64] = scan_di;
                            mdl_mem[(n - 1) / 2]   = ld_buf[DW-1:0];
                            mdl_known[(n - 1) / 2] = 1'b1;
                        end
                    end
                    exp_done = (n - 1 >= CHAIN - 1);
                end
            end else begin
                exp_do   = '0;
                exp_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            if (exp_rk) checkOutput("rdata", 128'(rdata), 128'(exp_rdata));
            checkOutput("scan_do", 128'(scan_do), 128'(exp_do));
            checkOutput("scan_done", 128'(scan_done), 128'(exp_done));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit fe, input bit we, input logic [5:0] wa,
                                 input logic [5:0] ra, input logic [DW-1:0] wd,
                                 input bit se, input bit sd, input logic [CW-1:0] di);
        func_en  = fe;
        wen      = we;
        waddr    = wa;
        raddr    = ra;
        wdata    = wd;
        scan_en  = se;
        scan_dir = sd;
        scan_di  = di;
        tick();
    endtask

    task automatic sApply(input bit fe, input bit we, input logic [3:0] wa,
                          input logic [3:0] ra, input logic [31:0] wd,
                          input bit se, input bit sd, input logic [31:0] di);
        s_func_en  = fe;
        s_wen      = we;
        s_waddr    = wa;
        s_raddr    = ra;
        s_wdata    = wd;
        s_scan_en  = se;
        s_scan_dir = sd;
        s_scan_di  = di;
        tick();
    endtask

    function automatic logic [DW-1:0] rand80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    function automatic logic [CW-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic writeWord(input int a, input logic [DW-1:0] d);
        applyStimulus(1'b1, 1'b1, 6'(a), 6'(a), d, 1'b0, 1'b0, '0);
    endtask

    task automatic readWord(input int a, output logic [DW-1:0] d);
        applyStimulus(1'b1, 1'b0, '0, 6'(a), '0, 1'b0, 1'b0, '0);
        d = rdata;
    endtask

    logic [DW-1:0] saved [4][DEPTH];
    logic [CW-1:0] img [4][CHAIN];
    logic [CW-1:0] ab_di [8];
    logic [31:0]   s_ref [16];
    logic [31:0]   s_img [16];

    // Dump the whole chain into img[r]; with pattern_chk the beats are also
    // compared against the mem[j] = j*3 fill.
    task automatic runDump(input int r, input bit pattern_chk);
        for (int c = 0; c <= CHAIN; c++) begin
            if (c == 0) begin
                checkOutput("dump_first", 128'(scan_do), 128'(0));
            end else begin
                img[r][c-1] = scan_do;
                if (pattern_chk)
                    checkOutput("dump_pattern", 128'(scan_do),
                                ((c - 1) % 2 == 0) ? 128'(((c - 1) / 2) * 3) : 128'(0));
            end
            applyStimulus(1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), rand80(),
                          1'b1, (c == 0) ? 1'b0 : 1'($urandom), rand64());
        end
        checkOutput("dump_done", 128'(scan_done), 128'(1));
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        checkOutput("dump_done_clr", 128'(scan_done), 128'(0));
    endtask

    // Restore nbeats beats from img[r] (or random beats kept in ab_di).
    task automatic runLoad(input int r, input int nbeats, input bit use_rand);
        logic [CW-1:0] di;
        for (int c = 0; c < nbeats; c++) begin
            di = use_rand ? rand64() : img[r][c];
            if (c < 8) ab_di[c] = di;
            applyStimulus(1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), rand80(),
                          1'b1, (c == 0) ? 1'b1 : 1'($urandom), di);
        end
        if (nbeats == CHAIN) begin
            checkOutput("load_done", 128'(scan_done), 128'(1));
            applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'($urandom), rand64());
            checkOutput("load_done_hold", 128'(scan_done), 128'(1));
            checkOutput("load_do_zero", 128'(scan_do), 128'(0));
        end
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        checkOutput("load_done_clr", 128'(scan_done), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] d, va, vb;

        // Reset values.
        repeat (3) tick();
        checkOutput("reset_rdata", 128'(rdata), 128'(0));
        checkOutput("reset_scan_do", 128'(scan_do), 128'(0));
        checkOutput("reset_scan_done", 128'(scan_done), 128'(0));
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);

        // Fill mem[j] = j*3 and a single literal read-back.
        for (int j = 0; j < DEPTH; j++) writeWord(j, DW'(j * 3));
        writeWord(5, 80'h1234_5678_9ABC_DEF0_1357);
        readWord(5, d);
        checkOutput("read_mem5", 128'(d), 128'(80'h1234_5678_9ABC_DEF0_1357));
        writeWord(5, DW'(15));
        runDump(0, 1'b1);

        // Random functional traffic, including paused cycles.
        for (int i = 0; i < 300; i++)
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 6'($urandom), 6'($urandom),
                          rand80(), 1'b0, 1'($urandom), rand64());

        // Four rounds of random fill + dump, then restore each and read back.
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < DEPTH; j++) begin
                saved[r][j] = rand80();
                writeWord(j, saved[r][j]);
            end
            runDump(r, 1'b0);
        end
        for (int r = 0; r < 4; r++) begin
            runLoad(r, CHAIN, 1'b0);
            for (int j = 0; j < DEPTH; j++) begin
                readWord(j, d);
                checkOutput("round_trip", 128'(d), 128'(saved[r][j]));
            end
        end

        // Restore aborted after 7 beats: words 0-2 replaced, word 3 kept.
        runLoad(0, 7, 1'b1);
        for (int j = 0; j < 3; j++) begin
            readWord(j, d);
            checkOutput("abort_word", 128'(d), 128'({ab_di[2*j+1][15:0], ab_di[2*j]}));
        end
        readWord(3, d);
        checkOutput("abort_kept", 128'(d), 128'(saved[3][3]));

        // Same-cycle write and read of address 9.
        va = rand80();
        vb = ~va;
        writeWord(9, va);
        applyStimulus(1'b1, 1'b1, 6'd9, 6'd9, vb, 1'b0, 1'b0, '0);
        checkOutput("collision", 128'(rdata), BYP ? 128'(vb) : 128'(va));
        readWord(9, d);
        checkOutput("collision_after", 128'(d), 128'(vb));

        // Reset in the middle of a dump; scan_en stays high afterwards.
        for (int c = 0; c < 5; c++)
            applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
        rst_n = 1'b0;
        #2;
        checkOutput("midrst_rdata", 128'(rdata), 128'(0));
        checkOutput("midrst_scan_do", 128'(scan_do), 128'(0));
        checkOutput("midrst_scan_done", 128'(scan_done), 128'(0));
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
            checkOutput("norestart_do", 128'(scan_do), 128'(0));
            checkOutput("norestart_done", 128'(scan_done), 128'(0));
        end
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        runDump(0, 1'b0);

        // Narrow configuration: one beat per word, 16 beats per dump.
        for (int j = 0; j < 16; j++) begin
            s_ref[j] = $urandom;
            sApply(1'b1, 1'b1, 4'(j), '0, s_ref[j], 1'b0, 1'b0, '0);
        end
        checkOutput("s_first", 128'(s_scan_do), 128'(0));
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) begin
                checkOutput("s_beat", 128'(s_scan_do), 128'(s_ref[c-1]));
                checkOutput("s_busy", 128'(s_scan_done), 128'(0));
                s_img[c-1] = s_scan_do;
            end
            sApply(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
        end
        checkOutput("s_done", 128'(s_scan_done), 128'(1));
        sApply(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        for (int j = 0; j < 16; j++)
            sApply(1'b1, 1'b1, 4'(j), '0, ~s_ref[j], 1'b0, 1'b0, '0);
        for (int c = 0; c < 16; c++)
            sApply(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, s_img[c]);
        checkOutput("s_load_done", 128'(s_scan_done), 128'(1));
        sApply(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        for (int j = 0; j < 16; j++) begin
            sApply(1'b1, 1'b0, '0, 4'(j), '0, 1'b0, 1'b0, '0);
            checkOutput("s_round_trip", 128'(s_rdata), 128'(s_ref[j]));
        end

        repeat (2) tick();
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
